// File: rtl/branch_predictor_bht_if.sv
// Fetch/execute bundle between the pipeline and the branch history table.
interface branch_predictor_bht_if #(
  parameter int HIST_BITS = 6
);
  logic [31:0]          pc_f;
  logic [31:0]          instr_f;
  logic                 predict_taken_f;
  logic [31:0]          target_f;
  logic [HIST_BITS-1:0] hist_f;
  logic                 upd_valid_e;
  logic [31:0]          upd_pc_e;
  logic [HIST_BITS-1:0] upd_hist_e;
  logic                 upd_taken_e;
  logic                 redirect_e;
  logic [31:0]          act_target_e;
  logic [31:0]          branch_cnt;
  logic [31:0]          mispred_cnt;

  // Pipeline side: drives fetch/resolve information, consumes predictions.
  modport master (
    output pc_f, instr_f, upd_valid_e, upd_pc_e, upd_hist_e, upd_taken_e,
           redirect_e, act_target_e,
    input  predict_taken_f, target_f, hist_f, branch_cnt, mispred_cnt
  );

  // Predictor side.
  modport slave (
    input  pc_f, instr_f, upd_valid_e, upd_pc_e, upd_hist_e, upd_taken_e,
           redirect_e, act_target_e,
    output predict_taken_f, target_f, hist_f, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters with optional gshare
// indexing, static JAL-taken prediction and saturating statistics counters.
// Prediction is purely combinational; history and table update only when a
// conditional branch resolves in execute.
module branch_predictor_bht #(
  parameter int         INDEX_BITS = 6,
  parameter int         HIST_BITS  = 6,
  parameter int         GSHARE     = 1,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic                   clk,
  input logic                   reset,
  branch_predictor_bht_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            bht_q [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q;
  logic [31:0]           branch_q;
  logic [31:0]           mispred_q;

  logic                  is_b;
  logic                  is_j;
  logic [31:0]           imm;
  logic [INDEX_BITS-1:0] idx_f;
  logic [INDEX_BITS-1:0] idx_e;
  logic [1:0]            ctr_e;

  // Instruction decode: branch/jump class and sign-extended offset.
  always_comb begin
    is_b = 1'b0;
    is_j = 1'b0;
    imm  = '0;
    case (bus.instr_f[6:0])
      7'b1100011: begin
        is_b = 1'b1;
        imm  = {{20{bus.instr_f[31]}}, bus.instr_f[7], bus.instr_f[30:25],
                bus.instr_f[11:8], 1'b0};
      end
      7'b1101111: begin
        is_j = 1'b1;
        imm  = {{12{bus.instr_f[31]}}, bus.instr_f[19:12], bus.instr_f[20],
                bus.instr_f[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Table indices; history is zero-extended to the index width before hashing.
  always_comb begin
    idx_f = bus.pc_f[INDEX_BITS+1:2];
    idx_e = bus.upd_pc_e[INDEX_BITS+1:2];
    if (GSHARE != 0) begin
      idx_f = idx_f ^ INDEX_BITS'(ghr_q);
      idx_e = idx_e ^ INDEX_BITS'(bus.upd_hist_e);
    end
    ctr_e = bht_q[idx_e];
  end

  // Prediction outputs; an execute redirect overrides everything.
  always_comb begin
    bus.predict_taken_f = bus.redirect_e | is_j | (is_b & bht_q[idx_f][1]);
    bus.target_f        = bus.redirect_e ? bus.act_target_e : bus.pc_f + imm;
    bus.hist_f          = ghr_q;
    bus.branch_cnt      = branch_q;
    bus.mispred_cnt     = mispred_q;
  end

  // Counter table: saturating train on each resolved conditional branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= INIT_STATE;
    end else if (bus.upd_valid_e) begin
      if (bus.upd_taken_e) begin
        if (ctr_e != 2'b11) bht_q[idx_e] <= ctr_e + 2'b01;
      end else begin
        if (ctr_e != 2'b00) bht_q[idx_e] <= ctr_e - 2'b01;
      end
    end
  end

  // Global history shifts in the resolved outcome; the truncating cast also
  // covers a single-bit history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                ghr_q <= '0;
    else if (bus.upd_valid_e) ghr_q <= HIST_BITS'({ghr_q, bus.upd_taken_e});
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (bus.upd_valid_e && branch_q != 32'hFFFF_FFFF) branch_q  <= branch_q + 32'd1;
      if (bus.redirect_e  && mispred_q != 32'hFFFF_FFFF) mispred_q <= mispred_q + 32'd1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.upd_pc_e[31:INDEX_BITS+2], bus.upd_pc_e[1:0], bus.upd_hist_e};
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: a bimodal 64-entry instance and a gshare
// 16-entry instance share stimulus and are compared against a table model.
module tb_branch_predictor_bht;
  localparam int I0 = 6, H0 = 6, I1 = 4, H1 = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_bht_if #(.HIST_BITS(H0)) b0 ();
  branch_predictor_bht_if #(.HIST_BITS(H1)) b1 ();

  branch_predictor_bht #(.INDEX_BITS(I0), .HIST_BITS(H0), .GSHARE(0), .INIT_STATE(2'b01))
    dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  branch_predictor_bht #(.INDEX_BITS(I1), .HIST_BITS(H1), .GSHARE(1), .INIT_STATE(2'b01))
    dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  int errors = 0;
  int checks = 0;

  // reference model state
  int     t0 [64];
  int     t1 [16];
  int     g0, g1;
  longint bc0, mc0, bc1, mc1;

  // current stimulus
  logic [31:0] s_pc, s_instr, s_upc, s_at;
  int          s_kind, s_imm, s_h0, s_h1;
  logic        s_uv, s_ut, s_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'd3, 5'd7, 3'b001, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic int mdl_idx(input logic [31:0] pc, input int ib, input int hist, input bit gs);
    int base;
    base = int'(pc >> 2) & ((1 << ib) - 1);
    return gs ? (base ^ hist) : base;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) t0[i] = 1;
    for (int i = 0; i < 16; i++) t1[i] = 1;
    g0 = 0; g1 = 0; bc0 = 0; mc0 = 0; bc1 = 0; mc1 = 0;
  endtask

  task automatic set_fetch(input logic [31:0] pc, input int kind, input int imm);
    s_pc = pc; s_kind = kind; s_imm = imm;
    case (kind)
      1:       s_instr = enc_b(imm);
      2:       s_instr = enc_j(imm);
      default: begin s_instr = 32'h0000_0013; s_imm = 0; end
    endcase
  endtask

  task automatic set_upd(input logic uv, input logic [31:0] upc, input logic ut,
                         input int h0, input int h1);
    s_uv = uv; s_upc = upc; s_ut = ut; s_h0 = h0; s_h1 = h1;
  endtask

  task automatic drive();
    logic [31:0] hv0, hv1;
    hv0 = s_h0; hv1 = s_h1;
    b0.pc_f = s_pc; b0.instr_f = s_instr; b0.upd_valid_e = s_uv; b0.upd_pc_e = s_upc;
    b0.upd_hist_e = hv0[H0-1:0]; b0.upd_taken_e = s_ut; b0.redirect_e = s_rd;
    b0.act_target_e = s_at;
    b1.pc_f = s_pc; b1.instr_f = s_instr; b1.upd_valid_e = s_uv; b1.upd_pc_e = s_upc;
    b1.upd_hist_e = hv1[H1-1:0]; b1.upd_taken_e = s_ut; b1.redirect_e = s_rd;
    b1.act_target_e = s_at;
  endtask

  task automatic check_all();
    logic [31:0] tgt;
    logic        pt0, pt1;
    tgt = s_rd ? s_at : s_pc + 32'(s_imm);
    pt0 = s_rd || s_kind == 2 || (s_kind == 1 && t0[mdl_idx(s_pc, I0, g0, 1'b0)] >= 2);
    pt1 = s_rd || s_kind == 2 || (s_kind == 1 && t1[mdl_idx(s_pc, I1, g1, 1'b1)] >= 2);
    chk("d0_predict", {31'd0, b0.predict_taken_f}, {31'd0, pt0});
    chk("d0_target", b0.target_f, tgt);
    chk("d0_hist", {26'd0, b0.hist_f}, 32'(g0));
    chk("d0_branch_cnt", b0.branch_cnt, 32'(bc0));
    chk("d0_mispred_cnt", b0.mispred_cnt, 32'(mc0));
    chk("d1_predict", {31'd0, b1.predict_taken_f}, {31'd0, pt1});
    chk("d1_target", b1.target_f, tgt);
    chk("d1_hist", {28'd0, b1.hist_f}, 32'(g1));
    chk("d1_branch_cnt", b1.branch_cnt, 32'(bc1));
    chk("d1_mispred_cnt", b1.mispred_cnt, 32'(mc1));
  endtask

  // apply, check, then clock the model alongside the DUTs
  task automatic step();
    int i;
    drive();
    #1 check_all();
    @(posedge clk);
    if (!reset) begin
      if (s_uv) begin
        i = mdl_idx(s_upc, I0, s_h0 & ((1 << H0) - 1), 1'b0);
        t0[i] = s_ut ? ((t0[i] == 3) ? 3 : t0[i] + 1) : ((t0[i] == 0) ? 0 : t0[i] - 1);
        i = mdl_idx(s_upc, I1, s_h1 & ((1 << H1) - 1), 1'b1);
        t1[i] = s_ut ? ((t1[i] == 3) ? 3 : t1[i] + 1) : ((t1[i] == 0) ? 0 : t1[i] - 1);
        g0 = ((g0 << 1) | int'(s_ut)) & ((1 << H0) - 1);
        g1 = ((g1 << 1) | int'(s_ut)) & ((1 << H1) - 1);
        if (bc0 < 64'hFFFF_FFFF) bc0++;
        if (bc1 < 64'hFFFF_FFFF) bc1++;
      end
      if (s_rd) begin
        if (mc0 < 64'hFFFF_FFFF) mc0++;
        if (mc1 < 64'hFFFF_FFFF) mc1++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    s_rd = 1'b0; s_at = 32'h0;
    set_fetch(32'h100, 1, 16);
    set_upd(1'b0, 32'h0, 1'b0, 0, 0);
    drive();
    @(negedge clk);

    // in reset: B-type not taken, JAL taken; an update while in reset is ignored
    set_fetch(32'h100, 1, 16);
    set_upd(1'b1, 32'h100, 1'b1, 0, 0);
    drive(); #1;
    chk("rst_b_pt", {31'd0, b0.predict_taken_f}, 32'd0);
    chk("rst_b_tgt", b0.target_f, 32'h110);
    step();
    set_fetch(32'h200, 2, -8);
    set_upd(1'b0, 32'h0, 1'b0, 0, 0);
    drive(); #1;
    chk("rst_j_pt", {31'd0, b0.predict_taken_f}, 32'd1);
    chk("rst_j_tgt", b0.target_f, 32'h1F8);
    step();
    reset = 1'b0;

    // training up to strongly taken, then down to strongly not-taken
    set_fetch(32'h100, 1, 16);
    for (int k = 0; k < 3; k++) begin
      set_upd(1'b1, 32'h100, 1'b1, 0, 0);
      step();
      drive(); #1;
      chk("train_up_pt", {31'd0, b0.predict_taken_f}, 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      set_upd(1'b1, 32'h100, 1'b0, 0, 0);
      step();
    end
    set_upd(1'b0, 32'h0, 1'b0, 0, 0);
    drive(); #1;
    chk("train_down_pt", {31'd0, b0.predict_taken_f}, 32'd0);
    step();

    // fresh start for gshare indexing
    reset = 1'b1; model_reset();
    step();
    reset = 1'b0;
    set_fetch(32'h40, 1, 8);
    set_upd(1'b1, 32'h40, 1'b1, 0, 0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 0, 0);
    drive(); #1;
    chk("gs_hist", {28'd0, b1.hist_f}, 32'h1);
    chk("gs_entry1_pt", {31'd0, b1.predict_taken_f}, 32'd0);
    step();
    set_fetch(32'h44, 1, 8);
    drive(); #1;
    chk("gs_entry0_pt", {31'd0, b1.predict_taken_f}, 32'd1);
    step();

    // redirect without an update: override target, count, leave history
    set_fetch(32'h80, 0, 0);
    s_rd = 1'b1; s_at = 32'h3000;
    drive(); #1;
    chk("rd_pt", {31'd0, b1.predict_taken_f}, 32'd1);
    chk("rd_tgt", b1.target_f, 32'h3000);
    step();
    s_rd = 1'b0;
    set_fetch(32'h44, 1, 8);
    drive(); #1;
    chk("rd_mispred", b1.mispred_cnt, 32'd1);
    chk("rd_hist_kept", {28'd0, b1.hist_f}, 32'h1);
    chk("rd_table_kept", {31'd0, b1.predict_taken_f}, 32'd1);
    step();

    // same-index read and write in one cycle: old value first
    set_fetch(32'h104, 1, 4);
    set_upd(1'b1, 32'h104, 1'b1, 0, 0);
    drive(); #1;
    chk("bypass_old", {31'd0, b0.predict_taken_f}, 32'd0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 0, 0);
    drive(); #1;
    chk("bypass_new", {31'd0, b0.predict_taken_f}, 32'd1);
    step();

    // mispredict counter saturation
    force dut0.mispred_q = 32'hFFFF_FFFF;
    #1 release dut0.mispred_q;
    mc0 = 64'hFFFF_FFFF;
    @(negedge clk);
    s_rd = 1'b1; s_at = 32'h500;
    step();
    s_rd = 1'b0;
    drive(); #1;
    chk("mispred_sat", b0.mispred_cnt, 32'hFFFF_FFFF);
    step();

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      set_fetch({22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom_range(0, 2),
                ($urandom_range(0, 1) ? -1 : 1) * 2 * $urandom_range(0, 1000));
      set_upd($urandom_range(0, 1) == 1, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : g0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : g1);
      s_rd = ($urandom_range(0, 4) == 0);
      s_at = $urandom & 32'hFFFF_FFFC;
      step();
    end

    // asynchronous reset in mid-cycle
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("arst_hist", {28'd0, b1.hist_f}, 32'd0);
    chk("arst_bcnt", b1.branch_cnt, 32'd0);
    chk("arst_mcnt", b0.mispred_cnt, 32'd0);
    @(negedge clk);
    s_rd = 1'b0;
    set_fetch(32'h100, 1, 16);
    set_upd(1'b1, 32'h100, 1'b1, 0, 0);
    step();
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 0, 0);
    drive(); #1;
    chk("post_rst_pt", {31'd0, b0.predict_taken_f}, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Parametrised successor to the single-counter predictor. It holds a table of 2-bit saturating counters indexed by fetch PC, optionally XOR-hashed with a global history register (gshare mode). JAL is always predicted taken, and the block keeps saturating performance counters. It sits beside the fetch stage: prediction is combinational on the fetch-side inputs, update is driven by branch resolution in execute, and it redirects to the actual target on mispredict.

Parameters:
INDEX_BITS, 6, log2 of table entries (entries = 2**INDEX_BITS).
HIST_BITS, 6, global history length; legal range 1..INDEX_BITS.
GSHARE, 1, 1 = index is PC bits XOR history; 0 = bimodal, PC bits only (history still tracked).
INIT_STATE, 2'b01, reset value of every counter (00 SNT, 01 WNT, 10 WT, 11 ST).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
pc_f  in  32  fetch PC
instr_f  in  32  fetched instruction
predict_taken_f  out  1  redirect fetch to target_f
target_f  out  32  next-PC target when predict_taken_f=1 or redirect_e=1
hist_f  out  HIST_BITS  history snapshot used for this prediction; carried down the pipe
upd_valid_e  in  1  resolved conditional branch (B-type) in execute
upd_pc_e  in  32  PC of the resolved branch
upd_hist_e  in  HIST_BITS  hist_f value carried with that branch
upd_taken_e  in  1  actual outcome
redirect_e  in  1  execute mispredict; act_target_e overrides the prediction
act_target_e  in  32  correct next PC from execute
branch_cnt  out  32  resolved-branch count
mispred_cnt  out  32  mispredict count

Behaviour:
- Decode on instr_f[6:0]: 1100011 = B-type, imm {{20{i[31]}},i[7],i[30:25],i[11:8],0}; 1101111 = JAL, imm {{12{i[31]}},i[19:12],i[20],i[30:21],0}; otherwise imm = 0 (no X).
- Index: idx_f = pc_f[INDEX_BITS+1:2] XOR (GSHARE ? zero-extended ghr : 0). idx_e is computed the same way from upd_pc_e and upd_hist_e.
- predict_taken_f = redirect_e | JAL | (B-type & table[idx_f][1]). Combinational, zero latency.
- target_f = redirect_e ? act_target_e : pc_f + imm (32-bit wrap).
- hist_f = ghr.
- On upd_valid_e, at posedge: table[idx_e] saturates up if upd_taken_e, down otherwise. 11+taken stays 11; 00+not-taken stays 00.
- On upd_valid_e, at posedge: ghr <= {ghr[HIST_BITS-2:0], upd_taken_e}. For HIST_BITS=1, ghr <= upd_taken_e. History is non-speculative: it is updated at resolve only, never at fetch.
- Same-cycle read/write of the same index: the prediction sees the old counter value; the new value is visible next cycle.
- branch_cnt increments on upd_valid_e. mispred_cnt increments on redirect_e (covers branches and JALR). Both saturate at 32'hFFFFFFFF, with no wrap.
- redirect_e without upd_valid_e (e.g. JALR): no table or ghr change.
- Reset: all counters to INIT_STATE, ghr = 0, both stat counters = 0. Reset asserted mid-operation clears state immediately. No table update happens in a cycle where reset is high.
- Outputs in reset: predict_taken_f and target_f follow the combinational rules with a cleared table; with redirect_e=0 and INIT_STATE=01, B-type predicts not-taken and JAL predicts taken.
- No internal pipeline stalls; the block never backpressures.

Test Plan:
1. Reset, GSHARE=0, B-type at pc_f=0x100, imm=+16 -> predict_taken_f=0, target_f=0x110. JAL at 0x200 with imm=-8 -> predict_taken_f=1, target_f=0x1F8.
2. Three taken updates at upd_pc_e=0x100 -> counter 01→10→11→11; predict_taken_f=1 from the cycle after the first update. Four not-taken updates -> saturates at 00 and predicts 0.
3. GSHARE=1, INDEX_BITS=HIST_BITS=4: pc 0x40 (idx 0). Update taken with hist 0 -> ghr=0001. The same PC then reads entry 1 (untouched, predicts 0) while entry 0 holds 10.
4. redirect_e=1, act_target_e=0x3000, unrelated instr_f -> predict_taken_f=1, target_f=0x3000, mispred_cnt+1. With upd_valid_e=0, ghr and table are unchanged.
5. Update and fetch hit the same index in one cycle -> old prediction returned; new value appears next cycle.
6. Force mispred_cnt to 0xFFFFFFFF and issue another redirect -> stays 0xFFFFFFFF. Assert reset mid-stream -> all counters 01, ghr 0, stats 0, asynchronously.
